// File: rtl/cmsdk_apb_multi_timer_if.sv
// APB slave bus bundle for the multi-channel timer.
// PCLK/PRESET stay as plain ports on the timer itself.
interface cmsdk_apb_multi_timer_if;
    logic        PSEL;
    logic [9:0]  PADDR;
    logic        PENABLE;
    logic        PWRITE;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;

    modport master (
        output PSEL, PADDR, PENABLE, PWRITE, PWDATA,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        input  PSEL, PADDR, PENABLE, PWRITE, PWDATA,
        output PRDATA, PREADY, PSLVERR
    );
endinterface

// File: rtl/cmsdk_apb_multi_timer.sv
// Multi-channel APB down-counter timer: NUM_CH channels sharing one prescaler,
// each with periodic/one-shot mode, EXTIN gating or edge clocking, and a masked interrupt.
module cmsdk_apb_multi_timer #(
    parameter int NUM_CH     = 2,
    parameter int CNT_W      = 32,
    parameter int PRESCALE_W = 8
) (
    input  logic                  PCLK,
    input  logic                  PRESET,
    cmsdk_apb_multi_timer_if.slave apb,
    input  logic [NUM_CH-1:0]     EXTIN,
    output logic [NUM_CH-1:0]     TIMERINT,
    output logic                  TIMERINT_COMB
);
    localparam int EN = 0, EXTGATE = 1, EXTCLK = 2, IE = 3, ONESHOT = 4;

    logic [PRESCALE_W-1:0] prescale_q, prescale_d, pcnt_q, pcnt_d;
    logic [4:0]            ctrl_q   [NUM_CH];
    logic [4:0]            ctrl_d   [NUM_CH];
    logic [CNT_W-1:0]      value_q  [NUM_CH];
    logic [CNT_W-1:0]      value_d  [NUM_CH];
    logic [CNT_W-1:0]      reload_q [NUM_CH];
    logic [CNT_W-1:0]      reload_d [NUM_CH];
    logic [NUM_CH-1:0]     intstat_q, intstat_d, timerint_q, timerint_d;
    logic [NUM_CH-1:0]     sync1_q, sync1_d, sync2_q, sync2_d, dly_q, dly_d;

    logic                  wr_en, rd_en, sel_prescale, sel_intall, tick;
    logic [NUM_CH-1:0]     sel_ch, rise, dec;
    logic [31:0]           rdata;

    always_comb begin
        wr_en        = apb.PSEL & apb.PENABLE & apb.PWRITE;
        rd_en        = apb.PSEL & apb.PENABLE & ~apb.PWRITE;
        sel_prescale = (apb.PADDR == 10'h040);
        sel_intall   = (apb.PADDR == 10'h041);
        tick         = (pcnt_q == prescale_q);
        sel_ch       = '0;
        rise         = '0;
        dec          = '0;
        for (int n = 0; n < NUM_CH; n++) begin
            // Channel slots are 16 bytes apart in the low 256-byte window
            sel_ch[n] = (apb.PADDR[9:6] == 4'd0) && (apb.PADDR[5:2] == 4'(n));
            rise[n]   = sync2_q[n] & ~dly_q[n];
            dec[n]    = ctrl_q[n][EN] && tick &&
                        (!ctrl_q[n][EXTGATE] || sync2_q[n]) &&
                        (!ctrl_q[n][EXTCLK]  || rise[n]);
        end
    end

    always_comb begin
        prescale_d = prescale_q;
        pcnt_d     = tick ? '0 : pcnt_q + PRESCALE_W'(1);
        if (wr_en && sel_prescale) begin
            prescale_d = apb.PWDATA[PRESCALE_W-1:0];
            pcnt_d     = '0;
        end
        sync1_d    = EXTIN;
        sync2_d    = sync1_q;
        dly_d      = sync2_q;
        intstat_d  = intstat_q;
        timerint_d = '0;
        for (int n = 0; n < NUM_CH; n++) begin
            ctrl_d[n]   = ctrl_q[n];
            value_d[n]  = value_q[n];
            reload_d[n] = reload_q[n];
            timerint_d[n] = intstat_q[n] & ctrl_q[n][IE];
            if (wr_en && sel_ch[n] && apb.PADDR[1:0] == 2'd3 && apb.PWDATA[0])
                intstat_d[n] = 1'b0;
            // Counter event first so that bus writes below take priority over it
            if (dec[n]) begin
                if (value_q[n] != '0) begin
                    value_d[n] = value_q[n] - CNT_W'(1);
                end else if (ctrl_q[n][ONESHOT]) begin
                    intstat_d[n]  = 1'b1;
                    ctrl_d[n][EN] = 1'b0;
                end else begin
                    value_d[n]   = reload_q[n];
                    intstat_d[n] = 1'b1;
                end
            end
            if (wr_en && sel_ch[n]) begin
                case (apb.PADDR[1:0])
                    2'd0:    ctrl_d[n]   = apb.PWDATA[4:0];
                    2'd1:    value_d[n]  = apb.PWDATA[CNT_W-1:0];
                    2'd2:    reload_d[n] = apb.PWDATA[CNT_W-1:0];
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        rdata = '0;
        if (rd_en) begin
            for (int n = 0; n < NUM_CH; n++) begin
                if (sel_ch[n]) begin
                    case (apb.PADDR[1:0])
                        2'd0:    rdata = {27'd0, ctrl_q[n]};
                        2'd1:    rdata = 32'(value_q[n]);
                        2'd2:    rdata = 32'(reload_q[n]);
                        default: rdata = {31'd0, intstat_q[n]};
                    endcase
                end
            end
            if (sel_prescale) rdata = 32'(prescale_q);
            if (sel_intall)   rdata = 32'(intstat_q);
        end
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            prescale_q <= '0;
            pcnt_q     <= '0;
            intstat_q  <= '0;
            timerint_q <= '0;
            sync1_q    <= '0;
            sync2_q    <= '0;
            dly_q      <= '0;
            for (int n = 0; n < NUM_CH; n++) begin
                ctrl_q[n]   <= '0;
                value_q[n]  <= '0;
                reload_q[n] <= '0;
            end
        end else begin
            prescale_q <= prescale_d;
            pcnt_q     <= pcnt_d;
            intstat_q  <= intstat_d;
            timerint_q <= timerint_d;
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            dly_q      <= dly_d;
            ctrl_q     <= ctrl_d;
            value_q    <= value_d;
            reload_q   <= reload_d;
        end
    end

    assign apb.PRDATA  = rdata;
    assign apb.PREADY  = 1'b1;
    assign apb.PSLVERR = 1'b0;
    assign TIMERINT      = timerint_q;
    assign TIMERINT_COMB = |timerint_q;
endmodule

// File: tb/tb_cmsdk_apb_multi_timer.sv
// Scoreboard bench for cmsdk_apb_multi_timer (4 channels, 16-bit counters):
// read tasks queue expected data, a negedge monitor pops and compares on each read access.
module tb_cmsdk_apb_multi_timer;
    localparam int NCH = 4;
    localparam int CW  = 16;

    logic           PCLK = 1'b0;
    logic           PRESET = 1'b1;
    logic [NCH-1:0] EXTIN = '0;
    logic [NCH-1:0] TIMERINT;
    logic           TIMERINT_COMB;

    cmsdk_apb_multi_timer_if apb_if ();

    cmsdk_apb_multi_timer #(.NUM_CH(NCH), .CNT_W(CW), .PRESCALE_W(8)) dut (
        .PCLK          (PCLK),
        .PRESET        (PRESET),
        .apb           (apb_if.slave),
        .EXTIN         (EXTIN),
        .TIMERINT      (TIMERINT),
        .TIMERINT_COMB (TIMERINT_COMB)
    );

    always #5 PCLK = ~PCLK;

    typedef struct {
        string       name;
        logic [31:0] rdata;
        logic [4:0]  irq;
        bit          chk_irq;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_fail   = 0;

    // Monitor: one scoreboard entry per read access cycle
    always @(negedge PCLK) begin
        if (apb_if.PSEL && apb_if.PENABLE && !apb_if.PWRITE) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL sb_underflow: read data %h seen, no read was expected", apb_if.PRDATA);
            end else begin
                mon_e = sb.pop_front();
                n_checks++;
                if (apb_if.PRDATA !== mon_e.rdata) begin
                    n_fail++;
                    $display("FAIL %s: PRDATA got %h, expected %h", mon_e.name, apb_if.PRDATA, mon_e.rdata);
                end
                n_checks++;
                if (apb_if.PREADY !== 1'b1 || apb_if.PSLVERR !== 1'b0) begin
                    n_fail++;
                    $display("FAIL %s_bus_resp: PREADY/PSLVERR got %b/%b, expected 1/0",
                             mon_e.name, apb_if.PREADY, apb_if.PSLVERR);
                end
                if (mon_e.chk_irq) begin
                    n_checks++;
                    if ({TIMERINT_COMB, TIMERINT} !== mon_e.irq) begin
                        n_fail++;
                        $display("FAIL %s_irq: {COMB,TIMERINT} got %h, expected %h",
                                 mon_e.name, {TIMERINT_COMB, TIMERINT}, mon_e.irq);
                    end
                end
            end
        end
    end

    function automatic logic [11:0] ca(input int ch, input int off);
        return 12'(ch * 16 + off);
    endfunction

    task automatic idle(input int n);
        repeat (n) @(posedge PCLK);
        #1;
    endtask

    task automatic bus_idle();
        apb_if.PSEL    = 1'b0;
        apb_if.PENABLE = 1'b0;
        apb_if.PWRITE  = 1'b0;
    endtask

    task automatic wr(input logic [11:0] a, input logic [31:0] d);
        apb_if.PSEL    = 1'b1;
        apb_if.PENABLE = 1'b0;
        apb_if.PWRITE  = 1'b1;
        apb_if.PADDR   = a[11:2];
        apb_if.PWDATA  = d;
        @(posedge PCLK); #1 apb_if.PENABLE = 1'b1;
        @(posedge PCLK); #1 bus_idle();
    endtask

    task automatic rd_core(input logic [11:0] a, input logic [31:0] e, input bit ci,
                           input logic [4:0] irq, input string nm);
        exp_t x;
        x.name = nm; x.rdata = e; x.irq = irq; x.chk_irq = ci;
        sb.push_back(x);
        apb_if.PSEL    = 1'b1;
        apb_if.PENABLE = 1'b0;
        apb_if.PWRITE  = 1'b0;
        apb_if.PADDR   = a[11:2];
        @(posedge PCLK); #1 apb_if.PENABLE = 1'b1;
        @(posedge PCLK); #1 bus_idle();
    endtask

    task automatic rd(input logic [11:0] a, input logic [31:0] e, input string nm);
        rd_core(a, e, 1'b0, 5'h00, nm);
    endtask

    task automatic rdi(input logic [11:0] a, input logic [31:0] e, input logic [4:0] irq, input string nm);
        rd_core(a, e, 1'b1, irq, nm);
    endtask

    // Held access phase: one sample per cycle to observe cycle-by-cycle behaviour
    task automatic burst(input logic [11:0] a, input int n, input logic [31:0] ev [16],
                         input logic [4:0] iv [16], input bit ci, input string nm);
        exp_t x;
        for (int k = 0; k < n; k++) begin
            x.name = $sformatf("%s[%0d]", nm, k); x.rdata = ev[k]; x.irq = iv[k]; x.chk_irq = ci;
            sb.push_back(x);
        end
        apb_if.PSEL    = 1'b1;
        apb_if.PENABLE = 1'b0;
        apb_if.PWRITE  = 1'b0;
        apb_if.PADDR   = a[11:2];
        for (int k = 0; k < n; k++) begin
            @(posedge PCLK); #1 apb_if.PENABLE = 1'b1;
        end
        @(posedge PCLK); #1 bus_idle();
    endtask

    logic [31:0] ev [16];
    logic [4:0]  iv [16];

    initial begin
        bus_idle();
        apb_if.PADDR  = '0;
        apb_if.PWDATA = '0;
        repeat (2) @(posedge PCLK);
        #1 PRESET = 1'b0;

        // Reset state plus writes to unmapped addresses
        wr(12'h040, 32'hFFFF_FFFF);
        wr(12'h108, 32'hFFFF_FFFF);
        wr(12'h200, 32'hFFFF_FFFF);
        for (int ch = 0; ch < NCH; ch++)
            for (int r = 0; r < 4; r++)
                rdi(ca(ch, r * 4), 32'h0, 5'h00, $sformatf("reset_ch%0d_reg%0d", ch, r));
        rdi(12'h100, 32'h0, 5'h00, "reset_prescale");
        rdi(12'h104, 32'h0, 5'h00, "reset_intall");
        rd(12'h040, 32'h0, "unmapped_ch4");
        rd(12'h108, 32'h0, "unmapped_108");
        rd(12'h200, 32'h0, "unmapped_200");

        // Periodic count, interrupt one cycle after INTSTAT, W1C
        wr(ca(0, 8), 32'd3);
        wr(ca(0, 4), 32'd3);
        rd(ca(0, 4), 32'd3, "t2_value_init");
        wr(ca(0, 0), 32'h09);
        ev = '{2, 1, 0, 3, 2, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        iv = '{0, 0, 0, 0, 5'h11, 5'h11, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        burst(ca(0, 4), 6, ev, iv, 1'b1, "t2_periodic");
        wr(ca(0, 0), 32'h08);
        rdi(ca(0, 12), 32'd1, 5'h11, "t2_intstat_set");
        wr(ca(0, 12), 32'd1);
        rdi(ca(0, 12), 32'd0, 5'h00, "t2_intstat_w1c");
        rd(ca(0, 4), 32'd2, "t2_value_hold");

        // One-shot with PRESCALE=4: decrements 5 cycles apart
        wr(12'h100, 32'd4);
        wr(ca(1, 4), 32'd2);
        wr(ca(1, 0), 32'h19);
        rd(ca(1, 4), 32'd1, "t3_first_dec");
        rd(ca(1, 4), 32'd1, "t3_between_ticks");
        idle(2);
        rd(ca(1, 4), 32'd0, "t3_second_dec");
        rd(ca(1, 0), 32'h19, "t3_still_enabled");
        rdi(ca(1, 12), 32'd1, 5'h00, "t3_intstat_third_dec");
        rdi(ca(1, 0), 32'h18, 5'h12, "t3_en_cleared");
        rd(ca(1, 4), 32'd0, "t3_value_holds");
        rdi(12'h104, 32'h2, 5'h12, "t3_intall");
        wr(ca(1, 12), 32'd1);
        wr(12'h100, 32'd0);

        // EXTIN edge clocking, then EXTIN gating
        wr(ca(0, 4), 32'd10);
        wr(ca(0, 0), 32'h05);
        ev = '{10, 10, 9, 9, 9, 9, 8, 8, 8, 8, 7, 7, 7, 7, 6, 6};
        iv = '{default: 5'h00};
        fork
            burst(ca(0, 4), 16, ev, iv, 1'b0, "t4_extclk");
            begin
                for (int p = 0; p < 4; p++) begin
                    EXTIN[0] = 1'b1; idle(2);
                    EXTIN[0] = 1'b0; idle(2);
                end
            end
        join
        rd(ca(0, 4), 32'd6, "t4_after_pulses");
        wr(ca(0, 0), 32'h03);
        idle(5);
        rd(ca(0, 4), 32'd6, "t4_gate_low");
        EXTIN[0] = 1'b1; idle(3);
        EXTIN[0] = 1'b0; idle(4);
        rd(ca(0, 4), 32'd3, "t4_gate_high");
        wr(ca(0, 0), 32'h00);

        // VALUE write collides with a decrement
        wr(ca(0, 0), 32'h01);
        wr(ca(0, 4), 32'd100);
        rd(ca(0, 4), 32'd99, "t5_value_wr_beats_dec");
        wr(ca(0, 0), 32'h00);

        // PRESCALE=1 puts decrements on every other edge, aligned with write commits
        wr(12'h100, 32'd1);
        wr(ca(2, 0), 32'h19);
        wr(ca(2, 12), 32'd1);
        wr(ca(3, 0), 32'h19);
        wr(ca(3, 0), 32'h09);
        rd(ca(2, 12), 32'd1, "t5_set_beats_w1c");
        rd(ca(2, 0), 32'h18, "t5_oneshot_auto_clear");
        rd(ca(3, 0), 32'h09, "t5_ctrl_wr_beats_auto_clear");
        rdi(12'h104, 32'hC, 5'h1C, "t5_intall_ch2_ch3");
        wr(ca(2, 12), 32'd1);
        rdi(12'h104, 32'h8, 5'h18, "t5_intall_ch3");
        wr(ca(3, 0), 32'h01);
        rdi(12'h104, 32'h8, 5'h00, "t5_ie_masked");
        wr(ca(3, 0), 32'h00);
        wr(ca(3, 12), 32'd1);
        wr(12'h100, 32'd0);
        rdi(12'h104, 32'h0, 5'h00, "t5_intall_clear");

        // Width truncation, reload independence, wrap from 0, mid-count reset
        wr(ca(1, 4), 32'h1234_5678);
        rd(ca(1, 4), 32'h5678, "t6_value_trunc");
        wr(ca(1, 8), 32'hABCD);
        rd(ca(1, 4), 32'h5678, "t6_reload_keeps_value");
        rd(ca(1, 8), 32'hABCD, "t6_reload");
        wr(ca(1, 4), 32'd0);
        wr(ca(1, 0), 32'h01);
        rd(ca(1, 4), 32'hABCD, "t6_wrap_to_reload");
        wr(12'h100, 32'd7);
        PRESET = 1'b1;
        @(posedge PCLK); #1 PRESET = 1'b0;
        rdi(ca(1, 4), 32'h0, 5'h00, "t6_reset_value");
        rd(ca(1, 0), 32'h0, "t6_reset_ctrl");
        rd(ca(1, 8), 32'h0, "t6_reset_reload");
        rd(ca(0, 8), 32'h0, "t6_reset_ch0_reload");
        rd(12'h100, 32'h0, "t6_reset_prescale");
        rdi(12'h104, 32'h0, 5'h00, "t6_reset_intall");

        idle(3);
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL sb_drain: %0d entries left, expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
